// File: rtl/vx_iter_div_unit_pkg.sv
// Shared divider definitions: FSM state encoding, iteration-count helper and M-op funct3 codes.
// Used by the divider top level and by decode upstream.
package vx_iter_div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // funct3 encodings of the divide M-ops, decoded upstream into is_signed/is_rem
    localparam logic [2:0] MOP_DIV  = 3'b100;
    localparam logic [2:0] MOP_DIVU = 3'b101;
    localparam logic [2:0] MOP_REM  = 3'b110;
    localparam logic [2:0] MOP_REMU = 3'b111;

    // cycles spent in CALC: one per group of radix_log quotient bits
    function automatic int div_iters(input int width, input int radix_log);
        return width / radix_log;
    endfunction

endpackage

// File: rtl/vx_iter_div_unit_if.sv
// Request/response bundle of the iterative divider; master = muldiv dispatch side, slave = divider.
// Valid/ready in both directions, one request in flight.
interface vx_iter_div_unit_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int TAGW  = 8
);
    logic                   valid_in;
    logic                   ready_in;
    logic                   is_signed;
    logic                   is_rem;
    logic [LANES*WIDTH-1:0] numer;
    logic [LANES*WIDTH-1:0] denom;
    logic [TAGW-1:0]        tag_in;
    logic                   valid_out;
    logic                   ready_out;
    logic [LANES*WIDTH-1:0] result;
    logic [TAGW-1:0]        tag_out;

    modport master (
        output valid_in, is_signed, is_rem, numer, denom, tag_in, ready_out,
        input  ready_in, valid_out, result, tag_out
    );

    modport slave (
        input  valid_in, is_signed, is_rem, numer, denom, tag_in, ready_out,
        output ready_in, valid_out, result, tag_out
    );
endinterface

// File: rtl/vx_iter_div_unit_div_lane.sv
// One lane: abs at load, RADIX_LOG restoring steps per cycle, sign fix-up into result on the last step.
// No handshake of its own; load/step/last are sequenced by the top-level FSM.
module vx_div_lane #(
    parameter int WIDTH     = 32,
    parameter int RADIX_LOG = 1
) (
    input  logic             clk,
    input  logic             load,
    input  logic             early,
    input  logic             step,
    input  logic             last,
    input  logic             is_signed,
    input  logic             is_rem,
    input  logic [WIDTH-1:0] numer,
    input  logic [WIDTH-1:0] denom,
    output logic             den_zero,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] rem_q, quo_q, den_q;
    logic             neg_quo_q, neg_rem_q, dz_q, sel_rem_q;

    logic             n_neg, d_neg;
    logic [WIDTH-1:0] n_abs, d_abs;
    logic [WIDTH-1:0] rem_d, quo_d, quo_fix, rem_fix;
    logic [WIDTH:0]   trial, diff;

    assign n_neg    = is_signed & numer[WIDTH-1];
    assign d_neg    = is_signed & denom[WIDTH-1];
    assign n_abs    = n_neg ? (~numer + 1'b1) : numer;
    assign d_abs    = d_neg ? (~denom + 1'b1) : denom;
    assign den_zero = (denom == '0);

    // The partial remainder is always below the divisor, so the shifted trial fits in WIDTH+1 bits.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        trial = '0;
        diff  = '0;
        for (int i = 0; i < RADIX_LOG; i++) begin
            trial = {rem_d, quo_d[WIDTH-1]};
            quo_d = {quo_d[WIDTH-2:0], 1'b0};
            diff  = trial - {1'b0, den_q};
            if (!diff[WIDTH]) begin
                rem_d    = diff[WIDTH-1:0];
                quo_d[0] = 1'b1;
            end else begin
                rem_d = trial[WIDTH-1:0];
            end
        end
    end

    // A zero divisor leaves quotient all ones and remainder |n|; MIN/-1 yields MIN, 0 with no special case.
    assign quo_fix = (neg_quo_q && !dz_q) ? (~quo_d + 1'b1) : quo_d;
    assign rem_fix = neg_rem_q ? (~rem_d + 1'b1) : rem_d;

    always_ff @(posedge clk) begin
        if (load) begin
            rem_q     <= '0;
            quo_q     <= n_abs;
            den_q     <= d_abs;
            neg_quo_q <= n_neg ^ d_neg;
            neg_rem_q <= n_neg;
            dz_q      <= den_zero;
            sel_rem_q <= is_rem;
            if (early) begin
                result <= is_rem ? numer : '1;
            end
        end else if (step) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (last) begin
                result <= sel_rem_q ? rem_fix : quo_fix;
            end
        end
    end
endmodule

// File: rtl/vx_iter_div_unit.sv
// Multi-lane iterative divider: result valid WIDTH/RADIX_LOG+1 cycles after accept, 1 on all-zero-divisor early-out.
// Single request in flight; result and tag held in DONE until ready_out, ready_in low while busy.
module vx_iter_div_unit
    import vx_iter_div_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LANES     = 4,
    parameter int RADIX_LOG = 1,
    parameter int TAGW      = 8,
    parameter int EARLY_OUT = 1
) (
    input  logic               clk,
    input  logic               reset,
    vx_iter_div_unit_if.slave  bus
);
    localparam int ITERS = div_iters(WIDTH, RADIX_LOG);
    localparam int CNTW  = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ITERS - 1);

    div_state_t             state_q, state_d;
    logic [CNTW-1:0]        cnt_q;
    logic [TAGW-1:0]        tag_q;
    logic [LANES-1:0]       den_zero;
    logic [LANES*WIDTH-1:0] result_w;
    logic                   accept, early_hit, calc_step, calc_last;

    assign bus.ready_in  = (state_q == IDLE);
    assign accept        = bus.valid_in && bus.ready_in;
    assign early_hit     = (EARLY_OUT != 0) && (&den_zero);
    assign calc_step     = (state_q == CALC);
    assign calc_last     = calc_step && (cnt_q == CNT_LAST);
    assign bus.valid_out = (state_q == DONE);
    assign bus.tag_out   = tag_q;
    assign bus.result    = result_w;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)        state_d = early_hit ? DONE : CALC;
            CALC: if (calc_last)     state_d = DONE;
            DONE: if (bus.ready_out) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter and tag only matter while busy, so they are left out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            cnt_q <= '0;
            tag_q <= bus.tag_in;
        end else if (calc_step) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vx_div_lane #(
            .WIDTH     (WIDTH),
            .RADIX_LOG (RADIX_LOG)
        ) u_lane (
            .clk       (clk),
            .load      (accept),
            .early     (early_hit),
            .step      (calc_step),
            .last      (calc_last),
            .is_signed (bus.is_signed),
            .is_rem    (bus.is_rem),
            .numer     (bus.numer[g*WIDTH +: WIDTH]),
            .denom     (bus.denom[g*WIDTH +: WIDTH]),
            .den_zero  (den_zero[g]),
            .result    (result_w[g*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_vx_iter_div_unit.sv
// Self-checking bench: a W=32/R=1/4-lane unit and a W=64/R=2/2-lane unit against a plain-arithmetic model.
// Covers directed vectors, early-out, backpressure, reset mid-flight and random traffic.
module tb_vx_iter_div_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_iter_div_unit_if #(.WIDTH(32), .LANES(4), .TAGW(8)) a_if ();
    vx_iter_div_unit_if #(.WIDTH(64), .LANES(2), .TAGW(8)) b_if ();

    vx_iter_div_unit #(.WIDTH(32), .LANES(4), .RADIX_LOG(1), .TAGW(8), .EARLY_OUT(1))
        dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
    vx_iter_div_unit #(.WIDTH(64), .LANES(2), .RADIX_LOG(2), .TAGW(8), .EARLY_OUT(1))
        dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

    typedef struct {
        bit          sgn;
        bit          rem;
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] st_n [4];
    logic [63:0] st_d [4];
    logic [63:0] got  [4];
    logic [7:0]  got_tag;
    vec_t        vt   [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Division defined by RISC-V rules on top of the simulator's own integer arithmetic.
    function automatic logic [63:0] ref_div(input logic [63:0] n, input logic [63:0] d,
                                            input int w, input bit sgn, input bit rem);
        logic [63:0] mask, un, ud, r;
        longint      sn, sd;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
        un = n & mask;
        ud = d & mask;
        if (w == 32) begin
            sn = longint'($signed(un[31:0]));
            sd = longint'($signed(ud[31:0]));
        end else begin
            sn = $signed(un);
            sd = $signed(ud);
        end
        if (ud == 0)
            r = rem ? un : mask;
        else if (sgn && w == 64 && un == 64'h8000_0000_0000_0000 && ud == '1)
            r = rem ? 64'd0 : un;
        else if (sgn)
            r = rem ? (sn % sd) : (sn / sd);
        else
            r = rem ? (un % ud) : (un / ud);
        return r & mask;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = (w == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
            3:       v = 64'($urandom_range(1, 20));
            default: v = {$urandom, $urandom};
        endcase
        return (w == 32) ? (v & 64'hFFFF_FFFF) : v;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? a_if.ready_in : b_if.ready_in;
    endfunction

    function automatic logic vout(input int sel);
        return (sel == 0) ? a_if.valid_out : b_if.valid_out;
    endfunction

    task automatic drive(input int sel, input bit sgn, input bit rem, input logic [7:0] tag, input bit vld);
        if (sel == 0) begin
            a_if.valid_in = vld; a_if.is_signed = sgn; a_if.is_rem = rem; a_if.tag_in = tag;
            for (int i = 0; i < 4; i++) begin
                a_if.numer[i*32 +: 32] = st_n[i][31:0];
                a_if.denom[i*32 +: 32] = st_d[i][31:0];
            end
        end else begin
            b_if.valid_in = vld; b_if.is_signed = sgn; b_if.is_rem = rem; b_if.tag_in = tag;
            for (int i = 0; i < 2; i++) begin
                b_if.numer[i*64 +: 64] = st_n[i];
                b_if.denom[i*64 +: 64] = st_d[i];
            end
        end
    endtask

    task automatic set_ready_out(input int sel, input logic v);
        if (sel == 0) a_if.ready_out = v;
        else          b_if.ready_out = v;
    endtask

    task automatic grab(input int sel);
        for (int i = 0; i < 4; i++)
            got[i] = (sel == 0) ? {32'd0, a_if.result[i*32 +: 32]}
                                : ((i < 2) ? b_if.result[i*64 +: 64] : 64'd0);
        got_tag = (sel == 0) ? a_if.tag_out : b_if.tag_out;
    endtask

    task automatic scramble(input int sel);
        for (int i = 0; i < 4; i++) begin
            st_n[i] = {$urandom, $urandom};
            st_d[i] = {$urandom, $urandom};
        end
        drive(sel, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    endtask

    // One full request: accept, wait for result, check latency/data/tag, hold, retire.
    task automatic txn(input int sel, input bit sgn, input bit rem, input logic [7:0] tag,
                       input int hold, input string name);
        int          lanes, w, exp_lat, lat;
        bit          all_z, stable;
        logic [63:0] exp_r [4];
        logic [63:0] snap  [4];
        logic [7:0]  snap_tag;
        lanes = (sel == 0) ? 4 : 2;
        w     = (sel == 0) ? 32 : 64;
        all_z = 1'b1;
        for (int i = 0; i < lanes; i++) begin
            exp_r[i] = ref_div(st_n[i], st_d[i], w, sgn, rem);
            if (((sel == 0) ? (st_d[i] & 64'hFFFF_FFFF) : st_d[i]) != 0) all_z = 1'b0;
        end
        exp_lat = all_z ? 1 : 33;
        check({name, " ready_in before accept"}, 64'(rdy(sel)), 64'd1);
        drive(sel, sgn, rem, tag, 1'b1);
        @(posedge clk); #1;
        scramble(sel);
        lat = 1;
        while (!vout(sel) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        grab(sel);
        for (int i = 0; i < lanes; i++)
            check($sformatf("%s lane%0d", name, i), got[i], exp_r[i]);
        check({name, " tag"}, 64'(got_tag), 64'(tag));
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            snap = got;
            snap_tag = got_tag;
            @(posedge clk); #1;
            grab(sel);
            if (!vout(sel) || rdy(sel) || got != snap || got_tag != snap_tag) stable = 1'b0;
        end
        if (hold > 0) check({name, " held under backpressure"}, 64'(stable), 64'd1);
        set_ready_out(sel, 1'b1);
        @(posedge clk); #1;
        set_ready_out(sel, 1'b0);
        check({name, " valid_out after retire"}, 64'(vout(sel)), 64'd0);
    endtask

    task automatic reset_mid_calc(input int sel, input int wait_cycles, input string name);
        for (int i = 0; i < 4; i++) begin
            st_n[i] = pick(64);
            st_d[i] = pick(64) | 64'd1;
        end
        drive(sel, 1'b1, 1'b0, 8'h5A, 1'b1);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (wait_cycles) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check({name, " valid_out after reset"}, 64'(vout(sel)), 64'd0);
        check({name, " ready_in after reset"},  64'(rdy(sel)),  64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14};
        vt[1]  = '{1'b0, 1'b1, 32'd100,        32'd7,          32'd2};
        vt[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vt[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vt[4]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vt[5]  = '{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1};
        vt[6]  = '{1'b1, 1'b0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
        vt[7]  = '{1'b1, 1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vt[8]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vt[9]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vt[10] = '{1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vt[11] = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vt[12] = '{1'b0, 1'b0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};

        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin st_n[i] = '0; st_d[i] = '0; end
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        set_ready_out(0, 1'b0);
        set_ready_out(1, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset a valid_out", 64'(a_if.valid_out), 64'd0);
        check("reset a ready_in",  64'(a_if.ready_in),  64'd1);
        check("reset b valid_out", 64'(b_if.valid_out), 64'd0);
        check("reset b ready_in",  64'(b_if.ready_in),  64'd1);

        // directed vectors on lane 0, random nonzero-divisor traffic on the other lanes
        for (int v = 0; v < 13; v++) begin
            st_n[0] = {32'd0, vt[v].n};
            st_d[0] = {32'd0, vt[v].d};
            for (int i = 1; i < 4; i++) begin
                st_n[i] = pick(32);
                st_d[i] = pick(32) | 64'd1;
            end
            txn(0, vt[v].sgn, vt[v].rem, 8'(v + 1), 0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d table", v), got[0], {32'd0, vt[v].exp});
        end

        for (int i = 0; i < 4; i++) begin st_n[i] = pick(32); st_d[i] = '0; end
        txn(0, 1'b1, 1'b0, 8'hE0, 0, "early a quot");
        for (int i = 0; i < 4; i++) begin st_n[i] = pick(32); st_d[i] = '0; end
        txn(0, 1'b0, 1'b1, 8'hE1, 0, "early a rem");
        for (int i = 0; i < 4; i++) begin st_n[i] = pick(64); st_d[i] = '0; end
        txn(1, 1'b1, 1'b1, 8'hE2, 0, "early b rem");

        for (int i = 0; i < 4; i++) begin
            st_n[i] = pick(32);
            st_d[i] = (i % 2 == 1) ? 64'd0 : (pick(32) | 64'd1);
        end
        txn(0, 1'b1, 1'b0, 8'hC3, 0, "mixed zero lanes");

        for (int i = 0; i < 4; i++) begin st_n[i] = pick(32); st_d[i] = pick(32) | 64'd3; end
        txn(0, 1'b1, 1'b1, 8'hB0, 10, "backpressure a");
        for (int i = 0; i < 4; i++) begin st_n[i] = pick(32); st_d[i] = pick(32) | 64'd1; end
        txn(0, 1'b0, 1'b0, 8'hB1, 0, "after backpressure a");
        for (int i = 0; i < 4; i++) begin st_n[i] = pick(64); st_d[i] = pick(64) | 64'd1; end
        txn(1, 1'b1, 1'b0, 8'hB2, 10, "backpressure b");

        reset_mid_calc(0, 10, "reset calc a");
        for (int i = 0; i < 4; i++) begin st_n[i] = 64'd100; st_d[i] = 64'd7; end
        txn(0, 1'b0, 1'b0, 8'h71, 0, "after reset a");
        reset_mid_calc(1, 12, "reset calc b");
        for (int i = 0; i < 4; i++) begin st_n[i] = pick(64); st_d[i] = pick(64) | 64'd1; end
        txn(1, 1'b1, 1'b1, 8'h72, 0, "after reset b");
        reset_mid_calc(0, 40, "reset done a");

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 4; i++) begin st_n[i] = pick(32); st_d[i] = pick(32); end
            txn(0, 1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3),
                $sformatf("rand a%0d", t));
        end
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 4; i++) begin st_n[i] = pick(64); st_d[i] = pick(64); end
            txn(1, 1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3),
                $sformatf("rand b%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
